// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing generator with four selectable test patterns.
// Ports: pclk/rst (sync, active-high); mode, fg_rgb pattern controls (latched at frame start);
//        hs, vs, de, red/green/blue, frame_start, frame_cnt: all registered, 1-cycle latency.
module vga_pattern_gen #(
  parameter int   H_ACTIVE   = 800,
  parameter int   H_FP       = 56,
  parameter int   H_SYNC     = 120,
  parameter int   H_BP       = 64,
  parameter int   V_ACTIVE   = 600,
  parameter int   V_FP       = 37,
  parameter int   V_SYNC     = 6,
  parameter int   V_BP       = 23,
  parameter logic HS_POL     = 1'b1,
  parameter logic VS_POL     = 1'b1,
  parameter int   COLOR_W    = 4,
  parameter int   CHK_LOG2   = 5,
  parameter int   GRAD_SHIFT = 4
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   fg_rgb,
  output logic                   hs,
  output logic                   vs,
  output logic                   de,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   frame_start,
  output logic [15:0]            frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are wide enough for the totals, the checker bit and the gradient slice.
  localparam int HW0 = $clog2(H_TOTAL);
  localparam int HW1 = (HW0 > CHK_LOG2) ? HW0 : CHK_LOG2 + 1;
  localparam int HW  = (HW1 >= COLOR_W) ? HW1 : COLOR_W;
  localparam int VW0 = $clog2(V_TOTAL);
  localparam int VW  = (VW0 > CHK_LOG2) ? VW0 : CHK_LOG2 + 1;

  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_WL   = HW'(BAR_W);
  localparam logic [HW-1:0] BAR_MAX  = HW'(7);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);

  // ST_INIT holds the counters at (0,0) for one edge after reset so the
  // shadow registers are loaded before pixel (0,0) is produced, exactly as
  // they are on a normal end-of-frame wrap.
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   running;
  logic                   load_shadow;
  logic                   at_last;

  logic [HW-1:0]          h_cnt;
  logic [VW-1:0]          v_cnt;
  logic [1:0]             mode_sh;
  logic [3*COLOR_W-1:0]   fg_sh;

  logic                   active;
  logic [HW-1:0]          bar_q;
  logic [2:0]             bar_idx;
  logic [COLOR_W-1:0]     grad;
  logic [3*COLOR_W-1:0]   pix;
  logic                   hs_nxt;
  logic                   vs_nxt;

  // State register
  always_ff @(posedge pclk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    running     = 1'b0;
    load_shadow = 1'b0;
    case (state)
      ST_INIT: load_shadow = 1'b1;
      ST_RUN: begin
        running     = 1'b1;
        load_shadow = at_last;
      end
      default: ;
    endcase
  end

  assign at_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Raster counters
  always_ff @(posedge pclk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (running) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Frame counter and pattern shadows, both tied to the frame wrap
  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_cnt <= '0;
      mode_sh   <= '0;
      fg_sh     <= '0;
    end else begin
      if (running && at_last) frame_cnt <= frame_cnt + 16'd1;
      if (load_shadow) begin
        mode_sh <= mode;
        fg_sh   <= fg_rgb;
      end
    end
  end

  // Pixel generation from the current counter state
  always_comb begin
    active  = running && (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
    bar_q   = h_cnt / BAR_WL;
    bar_idx = (bar_q > BAR_MAX) ? 3'd7 : bar_q[2:0];
    grad    = COLOR_W'(h_cnt >> GRAD_SHIFT);
    pix     = '0;
    case (mode_sh)
      2'd0: pix = fg_sh;
      2'd1: pix = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
      2'd2: pix = (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) ? '0 : fg_sh;
      2'd3: pix = {grad, grad, grad};
      default: pix = '0;
    endcase
    if (!active) pix = '0;
    hs_nxt = (running && (h_cnt >= H_SS) && (h_cnt < H_SE)) ? HS_POL : ~HS_POL;
    vs_nxt = (running && (v_cnt >= V_SS) && (v_cnt < V_SE)) ? VS_POL : ~VS_POL;
  end

  // Output register: every output sees the same counter snapshot
  always_ff @(posedge pclk) begin
    if (rst) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else begin
      hs          <= hs_nxt;
      vs          <= vs_nxt;
      de          <= active;
      red         <= pix[3*COLOR_W-1:2*COLOR_W];
      green       <= pix[2*COLOR_W-1:COLOR_W];
      blue        <= pix[COLOR_W-1:0];
      frame_start <= running && (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule
